// File: rtl/hsv_core_commit_queue.sv
// hsv_core_commit_queue: execute-to-commit buffer.
// CHANNELS producers are arbitrated round-robin (at most one accept per
// cycle) into a DEPTH-entry FIFO that feeds the commit stage. A synchronous
// flush empties the queue on pipeline redirect without touching storage.
module hsv_core_commit_queue #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int NW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk_core,
    input  logic                      rst_core_n,
    input  logic                      flush,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_channel,
    output logic [NW-1:0]             count
);

    logic [CW-1:0]       rr_last_r;
    logic [PW-1:0]       wp_r;
    logic [PW-1:0]       rp_r;
    logic [NW-1:0]       count_r;
    logic [WIDTH-1:0]    data_mem_r [DEPTH];
    logic [CW-1:0]       chan_mem_r [DEPTH];

    logic [CHANNELS-1:0] grant_s;
    logic [CW-1:0]       grant_idx_s;
    logic [CW-1:0]       cand_s;
    logic                found_s;
    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic [WIDTH-1:0]    sel_data_s;

    assign full_s  = (count_r == NW'(DEPTH));
    assign empty_s = (count_r == {NW{1'b0}});

    // Round-robin search: first valid channel after rr_last, wrapping around.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = rr_last_r;
        cand_s      = rr_last_r;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand_s = CW'((int'(rr_last_r) + k) % CHANNELS);
            if (!found_s && in_valid[cand_s]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // One-hot grant vector and the granted channel's payload.
    always_comb begin
        grant_s    = {CHANNELS{1'b0}};
        sel_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (found_s && (grant_idx_s == CW'(i))) begin
                grant_s[i] = 1'b1;
                sel_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Accept only when there is room and no flush; out_ready is deliberately
    // not used here so a full queue never accepts in the same cycle as a pop.
    always_comb begin
        if (found_s && !full_s && !flush) begin
            push_s   = 1'b1;
            in_ready = grant_s;
        end else begin
            push_s   = 1'b0;
            in_ready = {CHANNELS{1'b0}};
        end
    end

    assign out_valid   = !empty_s && !flush;
    assign pop_s       = out_valid && out_ready;
    assign out_data    = data_mem_r[rp_r];
    assign out_channel = chan_mem_r[rp_r];
    assign count       = count_r;

    // Pointer, occupancy and arbiter state; flush wins over push and pop.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            wp_r      <= {PW{1'b0}};
            rp_r      <= {PW{1'b0}};
            count_r   <= {NW{1'b0}};
            rr_last_r <= CW'(CHANNELS - 1);
        end else if (flush) begin
            wp_r      <= {PW{1'b0}};
            rp_r      <= {PW{1'b0}};
            count_r   <= {NW{1'b0}};
        end else begin
            if (push_s) begin
                wp_r      <= wp_r + 1'b1;
                rr_last_r <= grant_idx_s;
            end
            if (pop_s) begin
                rp_r <= rp_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; not reset, only written on an accepted transfer.
    always_ff @(posedge clk_core) begin
        if (push_s) begin
            data_mem_r[wp_r] <= sel_data_s;
            chan_mem_r[wp_r] <= grant_idx_s;
        end
    end

endmodule

// File: tb/tb_hsv_core_commit_queue.sv
// Bench for hsv_core_commit_queue: directed vector table, a reset-mid-stream
// sequence, then randomized traffic against a queue-based reference model.
module tb_hsv_core_commit_queue;

    logic         clk_core = 1'b0;
    logic         rst_core_n;
    logic         flush;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_channel;
    logic [2:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_core = ~clk_core;

    hsv_core_commit_queue #(.WIDTH(32), .CHANNELS(4), .DEPTH(4)) dut (
        .clk_core    (clk_core),
        .rst_core_n  (rst_core_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_channel (out_channel),
        .count       (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] chd(input int ch);
        return 32'hA5A5_0000 + ch;
    endfunction

    typedef struct {
        logic       do_rst;
        logic [3:0] valid;
        logic       ordy;
        logic       fl;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_ch;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] v, input logic o, input logic f,
                                input logic [3:0] er, input logic eov, input logic [1:0] ech,
                                input logic [2:0] ecnt);
        vec_t x;
        x.do_rst = r; x.valid = v; x.ordy = o; x.fl = f;
        x.exp_rdy = er; x.exp_ov = eov; x.exp_ch = ech; x.exp_cnt = ecnt;
        vecs.push_back(x);
    endfunction

    task automatic apply_row(input vec_t r);
        @(negedge clk_core);
        if (r.do_rst) begin
            rst_core_n = 1'b0;
            #1;
            rst_core_n = 1'b1;
        end
        in_valid  = r.valid;
        out_ready = r.ordy;
        flush     = r.fl;
        in_data   = {chd(3), chd(2), chd(1), chd(0)};
        #1;
        check("vec_in_ready", {28'd0, in_ready}, {28'd0, r.exp_rdy});
        check("vec_out_valid", {31'd0, out_valid}, {31'd0, r.exp_ov});
        check("vec_count", {29'd0, count}, {29'd0, r.exp_cnt});
        if (r.exp_ov) begin
            check("vec_out_channel", {30'd0, out_channel}, {30'd0, r.exp_ch});
            check("vec_out_data", out_data, chd(int'(r.exp_ch)));
        end
    endtask

    // Reference model: a queue of accepted results plus the last-granted index.
    typedef struct {
        logic [31:0] data;
        int          ch;
    } ent_t;
    ent_t q[$];
    int   m_rr;

    function automatic int m_pick(input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_rr + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk_core);
        rst_core_n = 1'b0;
        #2;
        rst_core_n = 1'b1;
        m_rr = 3;
        q.delete();
    endtask

    initial begin
        rst_core_n = 1'b0;
        flush      = 1'b0;
        in_valid   = 4'b0000;
        out_ready  = 1'b0;
        in_data    = 128'd0;
        m_rr       = 3;
        #12;
        rst_core_n = 1'b1;

        // A: idle after reset, single push on channel 2, pop it
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd0);
        add(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd0, 3'd0);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 3'd1);
        // B: all channels valid, out_ready high: 0,1,2,3,0,1
        add(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 3'd0);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 3'd1);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 3'd1);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 3'd1);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3, 3'd1);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 3'd1);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 3'd1);
        // C: fill to 4, full blocks even with out_ready, push the cycle after pop
        add(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd0, 3'd0);
        add(1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd2, 3'd1);
        add(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd2, 3'd2);
        add(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd2, 3'd3);
        add(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 3'd4);
        add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 3'd4);
        add(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd3, 3'd3);
        // D: drain to 2, then push and pop together keeps count at 2
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 3'd4);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 3'd3);
        add(1'b0, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd1, 3'd2);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 3'd2);
        // E: flush at count 3 with channel 1 valid; rotation preserved
        add(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd2, 3'd2);
        add(1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 3'd3);
        add(1'b0, 4'b1011, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 3'd0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 3'd1);

        foreach (vecs[i]) apply_row(vecs[i]);

        // F: asynchronous reset with two entries queued
        do_reset();
        @(negedge clk_core);
        in_valid = 4'b0001; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk_core);
        in_valid = 4'b0010;
        @(negedge clk_core);
        in_valid = 4'b0000;
        #1;
        check("rst_pre_count", {29'd0, count}, 32'd2);
        rst_core_n = 1'b0;
        #1;
        check("rst_async_count", {29'd0, count}, 32'd0);
        check("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk_core);
        rst_core_n = 1'b1;
        in_valid = 4'b1001;
        #1;
        check("rst_prio_ch0", {28'd0, in_ready}, 32'h1);
        @(negedge clk_core);
        in_valid = 4'b0000;

        // Randomized traffic against the reference model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int pct;
            int g;
            logic [3:0] er;
            logic eov;
            pct = (cyc / 250) % 3 == 0 ? 25 : ((cyc / 250) % 3 == 1 ? 85 : 50);
            @(negedge clk_core);
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 99) < pct);
            flush     = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
            #1;
            g  = m_pick(in_valid);
            er = 4'b0000;
            if (g >= 0 && q.size() < 4 && !flush) er[g] = 1'b1;
            eov = (q.size() > 0) && !flush;
            check("rnd_in_ready", {28'd0, in_ready}, {28'd0, er});
            check("rnd_out_valid", {31'd0, out_valid}, {31'd0, eov});
            check("rnd_count", {29'd0, count}, q.size());
            if (eov) begin
                check("rnd_out_data", out_data, q[0].data);
                check("rnd_out_channel", {30'd0, out_channel}, q[0].ch);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (eov && out_ready) void'(q.pop_front());
                if (er != 4'b0000) begin
                    ent_t e;
                    e.data = in_data[g*32 +: 32];
                    e.ch   = g;
                    q.push_back(e);
                    m_rr = g;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
